// File: rtl/gaussian_nb_pkg.sv
// ---------------------------------------------------------------------------
// gaussian_nb_pkg : shared types, default widths and saturation helper
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package gaussian_nb_pkg;

  localparam int DEF_PROD_W = 42;
  localparam int DEF_ACC_W  = 48;

  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CMP   = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // Width-independent overflow classification from the operand and sum sign bits.
  function automatic sat_e sat_add(input logic a_neg, input logic b_neg, input logic s_neg);
    if (!a_neg && !b_neg && s_neg) return SAT_POS;
    if (a_neg && b_neg && !s_neg)  return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gaussian_nb_sat_acc.sv
// ---------------------------------------------------------------------------
// gaussian_nb_sat_acc : signed product accumulator; saturating when
// GAUSSIAN_NB_ACC_SAT_EN is defined, wrapping otherwise.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module gaussian_nb_sat_acc
  import gaussian_nb_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [PROD_W-1:0] i_din,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_din_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_next;

  assign w_din_ext = {{(ACC_W-PROD_W){i_din[PROD_W-1]}}, i_din};
  assign w_sum     = r_acc + w_din_ext;

`ifdef GAUSSIAN_NB_ACC_SAT_EN
  always_comb begin
    w_next = w_sum;
    case (sat_add(r_acc[ACC_W-1], w_din_ext[ACC_W-1], w_sum[ACC_W-1]))
      SAT_POS: w_next = {1'b0, {(ACC_W-1){1'b1}}};
      SAT_NEG: w_next = {1'b1, {(ACC_W-1){1'b0}}};
      default: w_next = w_sum;
    endcase
  end
`else
  assign w_next = w_sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_next;
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/gaussian_nb_score_argmax.sv
// ---------------------------------------------------------------------------
// gaussian_nb_score_argmax : per-class score accumulation and minimum-score
// class selection. Optional macro: GAUSSIAN_NB_ACC_SAT_EN (saturating acc).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module gaussian_nb_score_argmax
  import gaussian_nb_pkg::*;
#(
  parameter int NUM_CLASSES  = 4,
  parameter int NUM_FEATURES = 8,
  parameter int PROD_W       = DEF_PROD_W,
  parameter int ACC_W        = DEF_ACC_W,
  parameter int CLS_W        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic [CLS_W-1:0]  in_class,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic [ACC_W-1:0]  out_score,
  output logic              out_err
);

  localparam int c_feat_w = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [c_feat_w-1:0] c_last_feat = c_feat_w'(NUM_FEATURES - 1);
  localparam logic [CLS_W-1:0]    c_last_cls  = CLS_W'(NUM_CLASSES - 1);

  state_e                  r_state;
  logic [c_feat_w-1:0]     r_feat;
  logic [CLS_W-1:0]        r_cls;
  logic signed [ACC_W-1:0] r_best_score;
  logic [CLS_W-1:0]        r_best_class;
  logic                    r_err;
  logic                    r_out_valid;
  logic [CLS_W-1:0]        r_out_class;
  logic [ACC_W-1:0]        r_out_score;
  logic                    r_out_err;

  logic                    w_xfer;
  logic signed [ACC_W-1:0] w_acc;
  logic                    w_take;
  logic signed [ACC_W-1:0] w_win_score;
  logic [CLS_W-1:0]        w_win_class;

  assign in_ready = reset && (r_state == ST_ACCUM);
  assign w_xfer   = in_valid && in_ready;

  // The last beat of a class is written into the accumulator, so during CMP
  // the register already holds the full class sum.
  gaussian_nb_sat_acc #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (r_state == ST_CMP),
    .i_en   (w_xfer),
    .i_din  (in_data),
    .o_acc  (w_acc)
  );

  assign w_take      = (r_cls == '0) || (w_acc < r_best_score);
  assign w_win_score = w_take ? w_acc : r_best_score;
  assign w_win_class = w_take ? r_cls : r_best_class;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ACCUM;
      r_feat       <= '0;
      r_cls        <= '0;
      r_best_score <= '0;
      r_best_class <= '0;
      r_err        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_class  <= '0;
      r_out_score  <= '0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_xfer) begin
            if (in_class != r_cls) r_err <= 1'b1;
            if (r_feat == c_last_feat) r_state <= ST_CMP;
            else                       r_feat  <= r_feat + 1'b1;
          end
        end
        ST_CMP: begin
          r_best_score <= w_win_score;
          r_best_class <= w_win_class;
          r_feat       <= '0;
          if (r_cls == c_last_cls) begin
            r_state     <= ST_OUT;
            r_out_valid <= 1'b1;
            r_out_class <= w_win_class;
            r_out_score <= w_win_score;
            r_out_err   <= r_err;
          end else begin
            r_cls   <= r_cls + 1'b1;
            r_state <= ST_ACCUM;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cls       <= '0;
            r_feat      <= '0;
            r_err       <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_score = r_out_score;
  assign out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_gaussian_nb_score_argmax.sv
// ---------------------------------------------------------------------------
// tb_gaussian_nb_score_argmax : scoreboard bench for gaussian_nb_score_argmax
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gaussian_nb_score_argmax;

  localparam int NC = 4;
  localparam int NF = 8;
  localparam int PW = 42;
  localparam int AW = 44;
  localparam int CW = 2;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [PW-1:0] in_data   = '0;
  logic [CW-1:0] in_class  = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_class;
  logic [AW-1:0] out_score;
  logic          out_err;

  typedef struct {
    logic [CW-1:0] cls;
    logic [AW-1:0] score;
    logic          err;
  } exp_t;

  exp_t   sb[$];
  longint smp[NC][NF];
  int     n_vec = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  gaussian_nb_score_argmax #(
    .NUM_CLASSES  (NC),
    .NUM_FEATURES (NF),
    .PROD_W       (PW),
    .ACC_W        (AW),
    .CLS_W        (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_class  (in_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .out_err   (out_err)
  );

  function automatic longint acc_step(input longint a, input longint d);
    longint s;
    longint lim;
    s   = a + d;
    lim = 64'sd1 <<< (AW - 1);
`ifdef GAUSSIAN_NB_ACC_SAT_EN
    if (s > lim - 1)   s = lim - 1;
    else if (s < -lim) s = -lim;
`else
    s = s & ((lim <<< 1) - 1);
    if (s >= lim) s = s - (lim <<< 1);
`endif
    return s;
  endfunction

  function automatic exp_t model(input bit err);
    exp_t   e;
    longint best;
    longint a;
    int     bc;
    best = 0;
    bc   = 0;
    for (int c = 0; c < NC; c++) begin
      a = 0;
      for (int f = 0; f < NF; f++) a = acc_step(a, smp[c][f]);
      if (c == 0 || a < best) begin
        best = a;
        bc   = c;
      end
    end
    e.cls   = CW'(bc);
    e.score = AW'(best);
    e.err   = err;
    return e;
  endfunction

  task automatic send(input int nbeats, input int bad, input bit push);
    if (push) sb.push_back(model(bad >= 0));
    for (int i = 0; i < nbeats; i++) begin
      int c;
      int f;
      int t;
      longint v;
      c = i / NF;
      f = i % NF;
      v = smp[c][f];
      in_valid = 1'b1;
      in_data  = v[PW-1:0];
      in_class = (i == bad) ? CW'((c + 2) % NC) : CW'(c);
      t = 0;
      while (!in_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL in_ready_timeout: beat %0d got in_ready=%0b, required 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   t;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    if (!out_valid || sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_valid: out_valid=%0b queued=%0d, required valid result with queued entry",
               name, out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (out_class !== e.cls) begin
      n_bad++;
      $display("FAIL %s_class: got %0d, required %0d", name, out_class, e.cls);
    end
    n_vec++;
    if (out_score !== e.score) begin
      n_bad++;
      $display("FAIL %s_score: got %0d, required %0d", name, $signed(out_score), $signed(e.score));
    end
    n_vec++;
    if (out_err !== e.err) begin
      n_bad++;
      $display("FAIL %s_err: got %0b, required %0b", name, out_err, e.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_basic();
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) smp[c][f] = longint'((10 - c) * 100);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_class, out_score, out_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b cls=%0d score=%0d err=%0b, required all 0",
               in_ready, out_valid, out_class, out_score, out_err);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fill_basic();
    send(NC * NF, -1, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_n1: out_valid=%0b, required 0", out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_n2: out_valid=%0b, required 1", out_valid);
    end
    collect("basic");
  endtask

  task automatic test_tie();
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) smp[c][f] = 0;
    smp[0][0] = 1000;
    smp[3][0] = 1000;
    smp[1][0] = -500;
    for (int f = 0; f < 5; f++) smp[2][f] = -100;
    send(NC * NF, -1, 1'b1);
    collect("tie");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   t;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) smp[c][f] = (c == 2) ? longint'(-37 * f) : longint'(50 + c);
    out_ready = 1'b0;
    send(NC * NF, -1, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid || sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL bp_valid: out_valid=%0b queued=%0d, required valid result", out_valid, sb.size());
      out_ready = 1'b1;
      return;
    end
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({in_ready, out_valid, out_class, out_score, out_err} !== {1'b0, 1'b1, e.cls, e.score, e.err}) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d got rdy=%0b vld=%0b cls=%0d score=%0d err=%0b, required 0 1 %0d %0d %0b",
                 k, in_ready, out_valid, out_class, $signed(out_score), out_err, e.cls, $signed(e.score), e.err);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release: got vld=%0b rdy=%0b, required vld=0 rdy=1", out_valid, in_ready);
    end
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) smp[c][f] = longint'(((c * 7 + f * 3) % 11) - 5);
    send(NC * NF, -1, 1'b1);
    collect("bp_next");
  endtask

  task automatic test_seq_err();
    fill_basic();
    send(NC * NF, 2, 1'b1);
    collect("seqerr");
    send(NC * NF, -1, 1'b1);
    collect("seqerr_clean");
  endtask

  task automatic test_overflow();
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) smp[c][f] = (c == 3) ? ((64'sd1 <<< 41) - 1) : 64'sd1;
    send(NC * NF, -1, 1'b1);
    collect("overflow");
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) smp[c][f] = -1000;
    send(2 * NF + 3, -1, 1'b0);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_hold: got rdy=%0b vld=%0b, required 0 0", in_ready, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_result: out_valid seen=%0b, required 0", seen);
    end
    fill_basic();
    send(NC * NF, -1, 1'b1);
    collect("midreset_fresh");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_seq_err();
    test_overflow();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
